ahb_arb_slave_6: RTL and testbench

AHB_ARB_SLAVE_6 -- requirements
Module: ahb_arb_slave_6

---
 rtl/ahb_arb_slave_6_pkg.sv | 19 +
 rtl/ahb_arb_slave_6_if.sv | 27 ++
 rtl/ahb_rr_pick.sv | 36 +++
 rtl/ahb_arb_slave_6.sv | 106 ++++++++++
 tb/tb_ahb_arb_slave_6.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ahb_arb_slave_6_pkg.sv
// Shared types and helpers for the slave_6 arbiter.
//   arb_state_e : arbiter FSM state (no owner / one owner)
//   MaxChannels : largest supported number of competing masters
//   rr_next     : round-robin pointer advance with wrap
package ahb_arb_slave_6_pkg;

  localparam int unsigned MaxChannels = 16;

  typedef enum logic {
    StIdle,
    StOwned
  } arb_state_e;

  // Pointer value following a grant to channel idx, wrapping at n.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return ((idx + 1) >= n) ? 0 : (idx + 1);
  endfunction

endpackage

// File: rtl/ahb_arb_slave_6_if.sv
// Bus bundle between the per-master address decoders / slave_6 and the arbiter.
//   req, last, hready           : requests, final-beat flags, slave HREADY
//   sel_addr, sel_data          : one-hot selects for slave-side and master-side muxes
//   grant_id, grant_vld         : binary owner index and grant-valid flag
// Modports: master (stimulus side), slave (arbiter side).
interface ahb_arb_slave_6_if #(
  parameter int unsigned CHANNEL_NUM = 1,
  parameter int unsigned ID_W        = 4
);
  logic [CHANNEL_NUM-1:0] req;
  logic [CHANNEL_NUM-1:0] last;
  logic                   hready;
  logic [CHANNEL_NUM-1:0] sel_addr;
  logic [CHANNEL_NUM-1:0] sel_data;
  logic [ID_W-1:0]        grant_id;
  logic                   grant_vld;

  modport master (
    output req, last, hready,
    input  sel_addr, sel_data, grant_id, grant_vld
  );

  modport slave (
    input  req, last, hready,
    output sel_addr, sel_data, grant_id, grant_vld
  );
endinterface

// File: rtl/ahb_rr_pick.sv
// Combinational round-robin winner search.
//   req_i    : request vector
//   ptr_i    : highest-priority index this round
//   onehot_o : one-hot winner (all zero when none)
//   idx_o    : binary winner index (0 when none)
//   found_o  : a winner exists
// Search order is ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
module ahb_rr_pick #(
  parameter int unsigned N   = 1,
  parameter int unsigned IdW = 4
) (
  input  logic [N-1:0]   req_i,
  input  logic [IdW-1:0] ptr_i,
  output logic [N-1:0]   onehot_o,
  output logic [IdW-1:0] idx_o,
  output logic           found_o
);

  int unsigned cand;

  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    found_o  = 1'b0;
    cand     = 0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = (32'(ptr_i) + k) % N;
      if (!found_o && req_i[cand]) begin
        found_o        = 1'b1;
        onehot_o[cand] = 1'b1;
        idx_o          = IdW'(cand);
      end
    end
  end

endmodule

// File: rtl/ahb_arb_slave_6.sv
// Round-robin bus arbiter for slave_6.
//   hclk, hreset : clock, synchronous active-high reset
//   bus (slave)  : req/last/hready in; sel_addr/sel_data/grant_id/grant_vld out
// sel_addr drives the slave-side payload mux; sel_data is sel_addr delayed through
// the AHB address-to-data pipeline and drives the master-side return mux.
module ahb_arb_slave_6
  import ahb_arb_slave_6_pkg::*;
#(
  parameter int unsigned CHANNEL_NUM = 1,
  parameter int unsigned ID_W        = 4
) (
  input  logic             hclk,
  input  logic             hreset,
  ahb_arb_slave_6_if.slave bus
);

  arb_state_e             state_q, state_d;
  logic [CHANNEL_NUM-1:0] sel_addr_q, sel_addr_d;
  logic [CHANNEL_NUM-1:0] sel_data_q, sel_data_d;
  logic [ID_W-1:0]        rr_ptr_q, rr_ptr_d;

  logic [CHANNEL_NUM-1:0] pick_onehot;
  logic [ID_W-1:0]        pick_idx;
  logic                   pick_found;
  logic                   owner_last;
  logic                   owner_req;
  logic                   release_ok;

  // The pointer already sits one past the owner, so an owner that re-requests
  // after its last beat naturally ranks behind every other requester.
  ahb_rr_pick #(
    .N   (CHANNEL_NUM),
    .IdW (ID_W)
  ) u_pick (
    .req_i    (bus.req),
    .ptr_i    (rr_ptr_q),
    .onehot_o (pick_onehot),
    .idx_o    (pick_idx),
    .found_o  (pick_found)
  );

  assign owner_last = |(sel_addr_q & bus.last);
  assign owner_req  = |(sel_addr_q & bus.req);
  assign release_ok = bus.hready && (owner_last || !owner_req);

  always_comb begin
    state_d    = state_q;
    sel_addr_d = sel_addr_q;
    rr_ptr_d   = rr_ptr_q;
    sel_data_d = bus.hready ? sel_addr_q : sel_data_q;

    unique case (state_q)
      StIdle: begin
        if (pick_found) begin
          state_d    = StOwned;
          sel_addr_d = pick_onehot;
          rr_ptr_d   = ID_W'(rr_next(32'(pick_idx), CHANNEL_NUM));
        end
      end
      StOwned: begin
        if (release_ok) begin
          if (pick_found) begin
            // Hand over on the same edge, no idle bubble.
            sel_addr_d = pick_onehot;
            rr_ptr_d   = ID_W'(rr_next(32'(pick_idx), CHANNEL_NUM));
          end else begin
            state_d    = StIdle;
            sel_addr_d = '0;
          end
        end
      end
      default: begin
        state_d    = StIdle;
        sel_addr_d = '0;
      end
    endcase
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q    <= StIdle;
      sel_addr_q <= '0;
      sel_data_q <= '0;
      rr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      sel_addr_q <= sel_addr_d;
      sel_data_q <= sel_data_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  always_comb begin
    bus.grant_id = '0;
    for (int unsigned i = 0; i < CHANNEL_NUM; i++) begin
      if (sel_addr_q[i]) begin
        bus.grant_id = bus.grant_id | ID_W'(i);
      end
    end
  end

  assign bus.grant_vld = |sel_addr_q;
  assign bus.sel_addr  = sel_addr_q;
  assign bus.sel_data  = sel_data_q;

endmodule

// File: tb/tb_ahb_arb_slave_6.sv
// Self-checking bench for ahb_arb_slave_6 with four channels: directed scenarios
// plus a randomized run against a behavioural owner/pointer model.
module tb_ahb_arb_slave_6;
  localparam int unsigned N  = 4;
  localparam int unsigned IW = 4;

  logic hclk;
  logic hreset;
  int   checks;
  int   errors;

  // Reference model: owner index (-1 = none), data-phase owner, pointer.
  int m_owner;
  int m_data;
  int m_ptr;

  ahb_arb_slave_6_if #(.CHANNEL_NUM(N), .ID_W(IW)) bus ();

  ahb_arb_slave_6 #(
    .CHANNEL_NUM (N),
    .ID_W        (IW)
  ) dut (
    .hclk   (hclk),
    .hreset (hreset),
    .bus    (bus)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  function automatic logic [N-1:0] oh(input int i);
    logic [N-1:0] v;
    v = '0;
    if (i >= 0) v[i] = 1'b1;
    return v;
  endfunction

  // Advance one clock; the model consumes the inputs present at the edge.
  task automatic tick();
    int  n_owner;
    int  n_data;
    int  n_ptr;
    int  c;
    bit  rel;
    if (hreset) begin
      n_owner = -1;
      n_data  = -1;
      n_ptr   = 0;
    end else begin
      n_data  = bus.hready ? m_owner : m_data;
      n_owner = m_owner;
      n_ptr   = m_ptr;
      rel = (m_owner < 0) || (bus.hready && (bus.last[m_owner] || !bus.req[m_owner]));
      if (rel) begin
        n_owner = -1;
        for (int k = 0; k < N; k++) begin
          c = (m_ptr + k) % N;
          if (n_owner < 0 && bus.req[c]) begin
            n_owner = c;
            n_ptr   = (c + 1) % N;
          end
        end
      end
    end
    @(posedge hclk);
    #1;
    m_owner = n_owner;
    m_data  = n_data;
    m_ptr   = n_ptr;
  endtask

  task automatic do_reset();
    hreset     = 1'b1;
    bus.req    = '0;
    bus.last   = '0;
    bus.hready = 1'b1;
    tick();
    hreset = 1'b0;
  endtask

  task automatic test_reset();
    hreset     = 1'b1;
    bus.req    = 4'b1111;
    bus.last   = '0;
    bus.hready = 1'b0;
    tick();
    tick();
    checks++;
    if (bus.sel_addr !== 4'b0000) begin
      errors++; $display("FAIL reset_sel_addr got %b want 0000", bus.sel_addr);
    end
    checks++;
    if (bus.sel_data !== 4'b0000) begin
      errors++; $display("FAIL reset_sel_data got %b want 0000", bus.sel_data);
    end
    checks++;
    if (bus.grant_id !== 4'd0 || bus.grant_vld !== 1'b0) begin
      errors++;
      $display("FAIL reset_grant got id=%0d vld=%b want id=0 vld=0", bus.grant_id, bus.grant_vld);
    end
    hreset = 1'b0;
    bus.req = '0;
    bus.hready = 1'b1;
  endtask

  task automatic test_fairness();
    logic [N-1:0] want [3];
    want[0] = 4'b0001;
    want[1] = 4'b0100;
    want[2] = 4'b0001;
    do_reset();
    bus.req    = 4'b0101;
    bus.last   = 4'b0101;
    bus.hready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus.sel_addr !== want[i]) begin
        errors++; $display("FAIL fairness_c%0d got %b want %b", i + 1, bus.sel_addr, want[i]);
      end
    end
    checks++;
    if (bus.sel_data !== 4'b0100) begin
      errors++; $display("FAIL fairness_sel_data got %b want 0100", bus.sel_data);
    end
  endtask

  task automatic test_burst_wait();
    do_reset();
    bus.req    = 4'b0010;
    bus.last   = '0;
    bus.hready = 1'b1;
    tick();
    checks++;
    if (bus.sel_addr !== 4'b0010 || bus.grant_id !== 4'd1) begin
      errors++;
      $display("FAIL burst_grant got %b id=%0d want 0010 id=1", bus.sel_addr, bus.grant_id);
    end
    bus.req = 4'b1111;
    tick();
    // Wait states with other requesters toggling.
    for (int i = 0; i < 3; i++) begin
      bus.hready = 1'b0;
      bus.req    = 4'($urandom) | 4'b0010;
      bus.last   = 4'b0010;
      tick();
      checks++;
      if (bus.sel_addr !== 4'b0010) begin
        errors++; $display("FAIL burst_hold_w%0d got %b want 0010", i, bus.sel_addr);
      end
    end
    bus.req    = 4'b1111;
    bus.last   = '0;
    bus.hready = 1'b1;
    tick();
    tick();
    checks++;
    if (bus.sel_addr !== 4'b0010) begin
      errors++; $display("FAIL burst_hold_beat3 got %b want 0010", bus.sel_addr);
    end
    bus.last = 4'b0010;
    tick();
    checks++;
    if (bus.sel_addr !== 4'b0100) begin
      errors++; $display("FAIL burst_release got %b want 0100", bus.sel_addr);
    end
    bus.last = '0;
  endtask

  task automatic test_pipeline();
    do_reset();
    bus.req    = 4'b0001;
    bus.last   = 4'b0001;
    bus.hready = 1'b1;
    tick();
    checks++;
    if (bus.sel_addr !== 4'b0001 || bus.sel_data !== 4'b0000) begin
      errors++;
      $display("FAIL pipe_c1 got a=%b d=%b want a=0001 d=0000", bus.sel_addr, bus.sel_data);
    end
    bus.req  = 4'b1000;
    bus.last = 4'b1000;
    tick();
    checks++;
    if (bus.sel_addr !== 4'b1000 || bus.sel_data !== 4'b0001) begin
      errors++;
      $display("FAIL pipe_c2 got a=%b d=%b want a=1000 d=0001", bus.sel_addr, bus.sel_data);
    end
    bus.hready = 1'b0;
    tick();
    checks++;
    if (bus.sel_addr !== 4'b1000 || bus.sel_data !== 4'b0001) begin
      errors++;
      $display("FAIL pipe_freeze got a=%b d=%b want a=1000 d=0001", bus.sel_addr, bus.sel_data);
    end
    bus.hready = 1'b1;
    tick();
    checks++;
    if (bus.sel_addr !== 4'b1000 || bus.sel_data !== 4'b1000) begin
      errors++;
      $display("FAIL pipe_resume got a=%b d=%b want a=1000 d=1000", bus.sel_addr, bus.sel_data);
    end
  endtask

  task automatic test_single_master();
    do_reset();
    bus.req    = 4'b0001;
    bus.last   = 4'b0001;
    bus.hready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (bus.sel_addr !== 4'b0001 || bus.grant_vld !== 1'b1) begin
        errors++;
        $display("FAIL single_b2b_%0d got %b vld=%b want 0001 vld=1", i, bus.sel_addr,
                 bus.grant_vld);
      end
    end
    bus.req = 4'b0000;
    tick();
    checks++;
    if (bus.sel_addr !== 4'b0000 || bus.grant_vld !== 1'b0) begin
      errors++;
      $display("FAIL single_idle got %b vld=%b want 0000 vld=0", bus.sel_addr, bus.grant_vld);
    end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    bus.req    = 4'b0100;
    bus.last   = '0;
    bus.hready = 1'b1;
    tick();
    tick();
    bus.hready = 1'b0;
    tick();
    checks++;
    if (bus.sel_addr !== 4'b0100) begin
      errors++; $display("FAIL rstmid_owned got %b want 0100", bus.sel_addr);
    end
    hreset = 1'b1;
    tick();
    checks++;
    if (bus.sel_addr !== '0 || bus.sel_data !== '0 || bus.grant_id !== '0 ||
        bus.grant_vld !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_clear got a=%b d=%b id=%0d vld=%b want all 0", bus.sel_addr,
               bus.sel_data, bus.grant_id, bus.grant_vld);
    end
    hreset     = 1'b0;
    bus.req    = 4'b1100;
    bus.hready = 1'b1;
    tick();
    checks++;
    if (bus.sel_addr !== 4'b0100 || bus.grant_id !== 4'd2) begin
      errors++;
      $display("FAIL rstmid_regrant got %b id=%0d want 0100 id=2", bus.sel_addr, bus.grant_id);
    end
  endtask

  task automatic test_random();
    int bad;
    do_reset();
    bad = 0;
    for (int i = 0; i < 400; i++) begin
      hreset     = ($urandom_range(0, 59) == 0);
      bus.req    = 4'($urandom);
      bus.last   = 4'($urandom);
      bus.hready = ($urandom_range(0, 3) != 0);
      tick();
      checks++;
      if (bus.sel_addr !== oh(m_owner) || bus.sel_data !== oh(m_data) ||
          bus.grant_id !== IW'((m_owner < 0) ? 0 : m_owner) ||
          bus.grant_vld !== (m_owner >= 0)) begin
        errors++;
        if (bad < 10)
          $display("FAIL random_%0d got a=%b d=%b id=%0d vld=%b want a=%b d=%b", i,
                   bus.sel_addr, bus.sel_data, bus.grant_id, bus.grant_vld, oh(m_owner),
                   oh(m_data));
        bad++;
      end
      checks++;
      if (!$onehot0(bus.sel_addr) || !$onehot0(bus.sel_data) ||
          bus.grant_vld !== |bus.sel_addr) begin
        errors++;
        $display("FAIL random_onehot_%0d got a=%b d=%b vld=%b want onehot0, vld=|a", i,
                 bus.sel_addr, bus.sel_data, bus.grant_vld);
      end
    end
    hreset = 1'b0;
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    m_owner    = -1;
    m_data     = -1;
    m_ptr      = 0;
    hreset     = 1'b1;
    bus.req    = '0;
    bus.last   = '0;
    bus.hready = 1'b1;
    test_reset();
    test_fairness();
    test_burst_wait();
    test_pipeline();
    test_single_master();
    test_reset_mid_burst();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
